// File: rtl/mul_hilo_ctrl_pkg.sv
// Shared definitions for the EX-stage multiply / HI-LO controller.
package mul_hilo_ctrl_pkg;

  // MD op codes as presented on ex_op.
  typedef enum logic [3:0] {
    MdNop   = 4'd0,
    MdMult  = 4'd1,
    MdMultu = 4'd2,
    MdMadd  = 4'd3,
    MdMaddu = 4'd4,
    MdMsub  = 4'd5,
    MdMsubu = 4'd6,
    MdMthi  = 4'd7,
    MdMtlo  = 4'd8
  } md_op_e;

  // Controller states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusy  = 2'd1,
    StAbort = 2'd2
  } ctrl_state_e;

  // How a completed product is folded into {HI,LO}.
  typedef enum logic [1:0] {
    AccSet = 2'd0,
    AccAdd = 2'd1,
    AccSub = 2'd2
  } acc_mode_e;

  // Multiply-class ops occupy the contiguous range MULT..MSUBU.
  function automatic logic is_mul_op(input logic [3:0] op);
    return (op >= MdMult) && (op <= MdMsubu);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == MdMult) || (op == MdMadd) || (op == MdMsub);
  endfunction

  function automatic acc_mode_e acc_mode_of(input logic [3:0] op);
    if ((op == MdMadd) || (op == MdMaddu)) begin
      return AccAdd;
    end else if ((op == MdMsub) || (op == MdMsubu)) begin
      return AccSub;
    end
    return AccSet;
  endfunction

endpackage

// File: rtl/mul_hilo_ctrl_hilo_reg.sv
// 64-bit HI/LO architectural storage with direct and accumulate write paths.
module mul_hilo_ctrl_hilo_reg
  import mul_hilo_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        hi_we_i,
  input  logic        lo_we_i,
  input  logic [63:0] wr_data_i,
  input  logic        acc_we_i,
  input  acc_mode_e   acc_mode_i,
  input  logic [63:0] acc_data_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [63:0] hilo_q, hilo_d;

  // Next {HI,LO}: accumulate path folds the product into the current registered value.
  always_comb begin
    hilo_d = hilo_q;
    if (acc_we_i) begin
      unique case (acc_mode_i)
        AccSet:  hilo_d = acc_data_i;
        AccAdd:  hilo_d = hilo_q + acc_data_i;
        AccSub:  hilo_d = hilo_q - acc_data_i;
        default: hilo_d = hilo_q;
      endcase
    end
    if (hi_we_i) hilo_d[63:32] = wr_data_i[63:32];
    if (lo_we_i) hilo_d[31:0]  = wr_data_i[31:0];
  end

  // HI/LO storage register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hilo_q <= '0;
    end else begin
      hilo_q <= hilo_d;
    end
  end

  assign hi_o = hilo_q[63:32];
  assign lo_o = hilo_q[31:0];

endmodule

// File: rtl/mul_hilo_ctrl.sv
// EX-stage controller: launches multiplies, stalls while in flight, retires into HI/LO,
// services MTHI/MTLO and drains the multiplier after a flush.
module mul_hilo_ctrl
  import mul_hilo_ctrl_pkg::*;
#(
  parameter int unsigned ABORT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [3:0]  ex_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  input  logic [63:0] mul_result,
  input  logic        mul_ready,
  output logic        mul_start,
  output logic        mul_stop,
  output logic        mul_signed,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done
);

  localparam int unsigned     CntW    = $clog2(ABORT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(ABORT_CYCLES);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  ctrl_state_e     state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;

  logic hi_we, lo_we, acc_we;
  logic ex_go;

  assign ex_go = ex_valid & ~flush;
  assign mul_a = rs_data;
  assign mul_b = rt_data;
  assign done  = done_q;

  // Next-state, HI/LO write enables and multiplier/pipeline handshakes.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    mul_start  = 1'b0;
    mul_stop   = 1'b0;
    mul_signed = 1'b0;
    stall      = 1'b0;
    hi_we      = 1'b0;
    lo_we      = 1'b0;
    acc_we     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ex_go) begin
          if (is_mul_op(ex_op)) begin
            mul_start  = 1'b1;
            mul_signed = is_signed_op(ex_op);
            stall      = 1'b1;
            op_d       = ex_op;
            state_d    = StBusy;
          end else begin
            hi_we = (ex_op == MdMthi);
            lo_we = (ex_op == MdMtlo);
          end
        end
      end
      StBusy: begin
        // Flush wins over a coincident ready: the product is dropped.
        if (flush) begin
          mul_stop = 1'b1;
          cnt_d    = CntLoad;
          state_d  = StAbort;
        end else if (mul_ready) begin
          acc_we  = 1'b1;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          stall = 1'b1;
        end
      end
      StAbort: begin
        mul_stop = 1'b1;
        if (cnt_q == CntOne) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
        // New multiplies wait for IDLE; HI/LO moves proceed.
        if (ex_go) begin
          if (is_mul_op(ex_op)) begin
            stall = 1'b1;
          end else begin
            hi_we = (ex_op == MdMthi);
            lo_we = (ex_op == MdMtlo);
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Handshakes are quiet while reset is asserted, independent of EX inputs.
    if (!rst) begin
      mul_start  = 1'b0;
      mul_stop   = 1'b0;
      mul_signed = 1'b0;
      stall      = 1'b0;
    end
  end

  // Controller state, latched op, abort counter and done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      op_q    <= MdNop;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  mul_hilo_ctrl_hilo_reg u_hilo_reg (
    .clk_i      (clk),
    .rst_ni     (rst),
    .hi_we_i    (hi_we),
    .lo_we_i    (lo_we),
    .wr_data_i  ({rs_data, rs_data}),
    .acc_we_i   (acc_we),
    .acc_mode_i (acc_mode_of(op_q)),
    .acc_data_i (mul_result),
    .hi_o       (hi),
    .lo_o       (lo)
  );

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Directed bench for mul_hilo_ctrl with a done-driven scoreboard.
module tb_mul_hilo_ctrl;
  import mul_hilo_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0;
  logic [3:0]  ex_op = 4'd0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        flush = 1'b0;
  logic [63:0] mul_result = '0;
  logic        mul_ready = 1'b0;
  logic        mul_start, mul_stop, mul_signed, stall, done;
  logic [31:0] mul_a, mul_b, hi, lo;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] model = '0;

  always #5 clk = ~clk;

  mul_hilo_ctrl #(.ABORT_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_op      (ex_op),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .flush      (flush),
    .mul_result (mul_result),
    .mul_ready  (mul_ready),
    .mul_start  (mul_start),
    .mul_stop   (mul_stop),
    .mul_signed (mul_signed),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .stall      (stall),
    .hi         (hi),
    .lo         (lo),
    .done       (done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid  = 1'b0;
    ex_op     = 4'd0;
    flush     = 1'b0;
    mul_ready = 1'b0;
  endtask

  task automatic md_move(input logic [3:0] op, input logic [31:0] d, input logic [63:0] exp);
    ex_valid = 1'b1; ex_op = op; rs_data = d; flush = 1'b0; mul_ready = 1'b0;
    #1;
    chk("move_stall", stall, 0);
    chk("move_start", mul_start, 0);
    cyc();
    chk("move_hilo", {hi, lo}, exp);
    model = exp;
    idle_inputs();
  endtask

  task automatic issue_mul(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn);
    ex_valid = 1'b1; ex_op = op; rs_data = a; rt_data = b; flush = 1'b0; mul_ready = 1'b0;
    #1;
    chk("issue_start", mul_start, 1);
    chk("issue_signed", mul_signed, sgn);
    chk("issue_stall", stall, 1);
    chk("issue_operands", {mul_a, mul_b}, {a, b});
    cyc();
  endtask

  // Nominal latency: three stalled BUSY cycles, ready in the fourth cycle after issue.
  task automatic finish_mul(input logic [63:0] prod, input logic [63:0] exp);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("busy_stall", stall, 1);
      chk("busy_start", mul_start, 0);
      cyc();
    end
    mul_ready = 1'b1; mul_result = prod;
    exp_q.push_back(exp);
    #1;
    chk("ready_stall", stall, 0);
    chk("ready_stop", mul_stop, 0);
    cyc();
    chk("done_pulse", done, 1);
    chk("retired_hilo", {hi, lo}, exp);
    model = exp;
    idle_inputs();
    mul_result = '0;
  endtask

  // Scoreboard monitor: every done pulse consumes one expected {HI,LO}.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && done) begin
        if (exp_q.size() == 0) begin
          chk("done_without_request", done, 0);
        end else begin
          chk("sb_hilo", {hi, lo}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #1;
    chk("rst_hilo", {hi, lo}, 64'h0);
    chk("rst_done", done, 0);
    chk("rst_stall", stall, 0);
    chk("rst_start_stop", {mul_start, mul_stop}, 0);
    @(negedge clk);
    rst = 1'b1;
    cyc();

    // 1: signed MULT -2 * 3.
    issue_mul(MdMult, 32'hFFFF_FFFE, 32'd3, 1'b1);
    finish_mul(64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFA);

    // 2: MTHI/MTLO then MADDU.
    md_move(MdMthi, 32'h0000_0001, 64'h0000_0001_FFFF_FFFA);
    md_move(MdMtlo, 32'hFFFF_FFF8, 64'h0000_0001_FFFF_FFF8);
    issue_mul(MdMaddu, 32'h4, 32'h4, 1'b0);
    finish_mul(64'h0000_0000_0000_0010, 64'h0000_0002_0000_0008);

    // 3: MSUB from zero wraps.
    md_move(MdMthi, 32'h0, 64'h0000_0000_0000_0008);
    md_move(MdMtlo, 32'h0, 64'h0);
    issue_mul(MdMsub, 32'h1, 32'h1, 1'b1);
    finish_mul(64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF);

    // Remaining op variants.
    issue_mul(MdMultu, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    finish_mul(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0);
    issue_mul(MdMadd, 32'h1, 32'h1, 1'b1);
    finish_mul(64'h0000_0001_0000_0000, 64'h1234_5679_9ABC_DEF0);
    issue_mul(MdMsubu, 32'h1, 32'h1, 1'b0);
    finish_mul(64'h1234_5679_9ABC_DEF0, 64'h0);

    // Stray ready in IDLE and an undefined op are both ignored.
    ex_valid = 1'b1; ex_op = 4'hF; rs_data = 32'h1234; mul_ready = 1'b1;
    mul_result = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk("undef_stall", stall, 0);
    chk("undef_start", mul_start, 0);
    chk("undef_stop", mul_stop, 0);
    cyc();
    chk("idle_ready_hilo", {hi, lo}, model);
    chk("idle_ready_done", done, 0);
    idle_inputs();
    mul_result = '0;

    // 4: flush on the 2nd BUSY cycle, stray ready, new MULT waits for IDLE.
    md_move(MdMtlo, 32'h0000_0077, 64'h0000_0000_0000_0077);
    issue_mul(MdMult, 32'h5, 32'h6, 1'b1);
    ex_valid = 1'b1; ex_op = MdMult;
    cyc();
    flush = 1'b1;
    #1;
    chk("flush_stop_1", mul_stop, 1);
    chk("flush_stall", stall, 0);
    cyc();
    flush = 1'b0; ex_op = MdMult; rs_data = 32'd2; rt_data = 32'd3;
    mul_ready = 1'b1; mul_result = 64'h0000_0000_0000_001E;
    #1;
    chk("abort_stop_2", mul_stop, 1);
    chk("abort_stall_2", stall, 1);
    chk("abort_start_2", mul_start, 0);
    cyc();
    mul_ready = 1'b0;
    #1;
    chk("abort_stop_3", mul_stop, 1);
    chk("abort_stall_3", stall, 1);
    chk("abort_start_3", mul_start, 0);
    chk("abort_hilo", {hi, lo}, model);
    chk("abort_done", done, 0);
    cyc();
    issue_mul(MdMult, 32'd2, 32'd3, 1'b1);
    chk("reissue_stop", mul_stop, 0);
    finish_mul(64'h0000_0000_0000_0006, 64'h0000_0000_0000_0006);

    // 5: flush and ready in the same BUSY cycle; MTHI accepted during ABORT.
    issue_mul(MdMultu, 32'h7, 32'h7, 1'b0);
    flush = 1'b1; mul_ready = 1'b1; mul_result = 64'h0000_0000_0000_DEAD;
    #1;
    chk("flush_ready_stop", mul_stop, 1);
    chk("flush_ready_stall", stall, 0);
    cyc();
    idle_inputs();
    chk("flush_ready_done", done, 0);
    chk("flush_ready_hilo", {hi, lo}, model);
    ex_valid = 1'b1; ex_op = MdMthi; rs_data = 32'hA5A5_A5A5;
    #1;
    chk("abort_mthi_stop", mul_stop, 1);
    chk("abort_mthi_stall", stall, 0);
    cyc();
    chk("abort_mthi_hilo", {hi, lo}, 64'hA5A5_A5A5_0000_0006);
    model = 64'hA5A5_A5A5_0000_0006;
    idle_inputs();
    #1;
    chk("abort_tail_stop", mul_stop, 1);
    cyc();
    chk("abort_exit_stop", mul_stop, 0);

    // 6: asynchronous reset mid-BUSY, then MTLO on the first edge after release.
    issue_mul(MdMult, 32'h3, 32'h3, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_hilo", {hi, lo}, 64'h0);
    chk("async_rst_stall", stall, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_start_stop", {mul_start, mul_stop}, 0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    ex_valid = 1'b1; ex_op = MdMtlo; rs_data = 32'h5;
    cyc();
    chk("post_rst_mtlo", {hi, lo}, 64'h0000_0000_0000_0005);
    idle_inputs();
    cyc();
    cyc();

    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
